// File: rtl/ingress_segmenter_pkg.sv
// ingress_segmenter_pkg
// Shared constants, descriptor layout and FSM state type for the ingress
// segmenter. Frames are cut into 64-byte cells of four 16-byte beats; each
// frame yields one 16-bit descriptor {4'b0, dport, prio, cells}.
package ingress_segmenter_pkg;

    localparam int unsigned CELL_BEATS     = 4;
    localparam int unsigned DATA_W         = 128;
    localparam int unsigned DESC_W         = 16;
    localparam int unsigned LEN_W          = 11;
    localparam int unsigned CELLS_W        = 6;
    localparam int unsigned DESC_CELLS_LSB = 0;
    localparam int unsigned DESC_PRIO_LSB  = 6;
    localparam int unsigned DESC_DPORT_LSB = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DRAIN
    } seg_state_t;

    // Cells needed to carry len bytes; an empty frame still occupies one cell.
    function automatic logic [CELLS_W-1:0] cell_count(input logic [LEN_W-1:0] len);
        logic [LEN_W:0] sum;
        sum = {1'b0, len} + (LEN_W+1)'(63);
        return (len == '0) ? CELLS_W'(1) : sum[LEN_W:6];
    endfunction

    function automatic logic [DESC_W-1:0] make_desc(input logic [3:0]         dport,
                                                    input logic [1:0]         prio,
                                                    input logic [CELLS_W-1:0] cells);
        logic [DESC_W-1:0] d;
        d = '0;
        d[DESC_DPORT_LSB +: 4]       = dport;
        d[DESC_PRIO_LSB +: 2]        = prio;
        d[DESC_CELLS_LSB +: CELLS_W] = cells;
        return d;
    endfunction

endpackage

// File: rtl/ingress_segmenter_fifo.sv
// sync_fifo
// Single-clock show-ahead FIFO. dout always presents the head entry; rd pops
// it. A push while full is accepted when a pop happens in the same cycle.
// Ports: clk, rst (sync, active-high), din/wr (push), rd (pop),
//        dout (head entry), full, count (occupancy).
module sync_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             wr,
    input  logic             rd,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             empty;
    logic             do_wr;
    logic             do_rd;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign do_rd = rd & ~empty;
    assign do_wr = wr & (~full | do_rd);
    assign dout  = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) wptr <= next_ptr(wptr);
            if (do_rd) rptr <= next_ptr(rptr);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ingress_segmenter.sv
// ingress_segmenter
// Buffers incoming frame beats and emits them as fixed 4-beat cells toward
// admission, one descriptor per frame alongside beat 0 of its first cell.
// Short frames are zero-padded to their cell count; over-long frames are
// truncated, the excess beats drained and seg_err pulsed.
// Ports: clk, rstn (sync, active-high reset despite the name);
//        pkt_* : input beat stream with sop-qualified len/dport/prio;
//        data_in/data_wr : cell beats out; i_cell_ptr_fifo_din/_wr : descriptor;
//        i_cell_bp : holds off cell starts; seg_err : truncation pulse.
module ingress_segmenter
    import ingress_segmenter_pkg::*;
#(
    parameter int unsigned BEAT_DEPTH = 16,
    parameter int unsigned DESC_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [127:0]       pkt_data,
    input  logic               pkt_valid,
    output logic               pkt_ready,
    input  logic               pkt_sop,
    input  logic               pkt_eop,
    input  logic [10:0]        pkt_len,
    input  logic [3:0]         pkt_dport,
    input  logic [1:0]         pkt_prio,
    output logic [127:0]       data_in,
    output logic               data_wr,
    output logic [15:0]        i_cell_ptr_fifo_din,
    output logic               i_cell_ptr_fifo_wr,
    input  logic               i_cell_bp,
    output logic               seg_err
);

    localparam int unsigned BW  = DATA_W + 1;
    localparam int unsigned BCW = $clog2(BEAT_DEPTH + 1);
    localparam int unsigned DCW = $clog2(DESC_DEPTH + 1);

    logic [BW-1:0]      beat_dout;
    logic               beat_full;
    logic [BCW-1:0]     beat_count;
    logic               beat_push;
    logic               beat_pop;
    logic               beat_eop;
    logic [DESC_W-1:0]  desc_dout;
    logic               desc_full;
    logic [DCW-1:0]     desc_count;
    logic               desc_push;
    logic [BCW-1:0]     eop_cnt;
    logic               accept;
    logic               in_frame;

    seg_state_t         state;
    logic [1:0]         beat_idx;
    logic [CELLS_W-1:0] cells_left;
    logic               padding;

    logic               data_avail;
    logic               new_ok;
    logic               cont_ok;
    logic               go_new;
    logic               go_cont;
    logic               emit_beat;
    logic               use_pad;
    logic               drain_pop;

    assign pkt_ready = ~rstn & ~beat_full & ~desc_full;
    assign accept    = pkt_valid & pkt_ready;
    // Beats outside a frame (no sop seen) are accepted but discarded.
    assign beat_push = accept & (pkt_sop | in_frame);
    assign desc_push = accept & pkt_sop;
    assign beat_eop  = beat_dout[DATA_W];

    sync_fifo #(.WIDTH(BW), .DEPTH(BEAT_DEPTH)) u_beat_fifo (
        .clk   (clk),
        .rst   (rstn),
        .din   ({pkt_eop, pkt_data}),
        .wr    (beat_push),
        .rd    (beat_pop),
        .dout  (beat_dout),
        .full  (beat_full),
        .count (beat_count)
    );

    sync_fifo #(.WIDTH(DESC_W), .DEPTH(DESC_DEPTH)) u_desc_fifo (
        .clk   (clk),
        .rst   (rstn),
        .din   (make_desc(pkt_dport, pkt_prio, cell_count(pkt_len))),
        .wr    (desc_push),
        .rd    (go_new),
        .dout  (desc_dout),
        .full  (desc_full),
        .count (desc_count)
    );

    // A cell may start once it can be fed without underflow: four beats
    // buffered, or the frame end already buffered (rest is padding).
    assign data_avail = (beat_count >= BCW'(CELL_BEATS)) | (eop_cnt != '0);
    assign new_ok     = (desc_count != '0) & ~i_cell_bp & data_avail;
    // Continuation cells of a frame have no descriptor left to wait on.
    assign cont_ok    = ~i_cell_bp & (data_avail | padding);

    always_comb begin
        go_new    = 1'b0;
        go_cont   = 1'b0;
        drain_pop = 1'b0;
        case (state)
            ST_IDLE:  go_new = new_ok;
            ST_SEND: begin
                if (beat_idx == 2'd0) begin
                    if (cells_left != '0) go_cont = cont_ok;
                    else if (padding)     go_new  = new_ok;
                end
            end
            ST_DRAIN: drain_pop = (beat_count != '0);
            default:  ;
        endcase
        emit_beat = go_new | go_cont | ((state == ST_SEND) && (beat_idx != 2'd0));
        use_pad   = padding & ~go_new;
        beat_pop  = (emit_beat & ~use_pad) | drain_pop;
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state               <= ST_IDLE;
            beat_idx            <= '0;
            cells_left          <= '0;
            padding             <= 1'b0;
            in_frame            <= 1'b0;
            eop_cnt             <= '0;
            data_in             <= '0;
            data_wr             <= 1'b0;
            i_cell_ptr_fifo_din <= '0;
            i_cell_ptr_fifo_wr  <= 1'b0;
            seg_err             <= 1'b0;
        end else begin
            data_wr             <= emit_beat;
            data_in             <= (emit_beat && !use_pad) ? beat_dout[DATA_W-1:0] : '0;
            i_cell_ptr_fifo_wr  <= go_new;
            i_cell_ptr_fifo_din <= go_new ? desc_dout : '0;
            seg_err             <= drain_pop & beat_eop;

            if (accept) begin
                if (pkt_sop)      in_frame <= ~pkt_eop;
                else if (pkt_eop) in_frame <= 1'b0;
            end

            case ({beat_push & pkt_eop, beat_pop & beat_eop & (beat_count != '0)})
                2'b10:   eop_cnt <= eop_cnt + BCW'(1);
                2'b01:   eop_cnt <= eop_cnt - BCW'(1);
                default: eop_cnt <= eop_cnt;
            endcase

            if (emit_beat) beat_idx <= beat_idx + 2'd1;

            // Once the eop beat leaves the FIFO the frame switches to padding.
            if (go_new)
                padding <= beat_eop;
            else if (beat_pop && state == ST_SEND)
                padding <= beat_eop;

            case (state)
                ST_IDLE: begin
                    if (go_new) begin
                        state      <= ST_SEND;
                        cells_left <= desc_dout[DESC_CELLS_LSB +: CELLS_W] - CELLS_W'(1);
                    end
                end
                ST_SEND: begin
                    if (go_new) begin
                        cells_left <= desc_dout[DESC_CELLS_LSB +: CELLS_W] - CELLS_W'(1);
                    end else if (go_cont) begin
                        cells_left <= cells_left - CELLS_W'(1);
                    end else if (beat_idx == 2'd0 && cells_left == '0) begin
                        state <= padding ? ST_IDLE : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_pop && beat_eop) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ingress_segmenter.sv
// tb_ingress_segmenter
// Directed bench for ingress_segmenter: drives frames, collects emitted cell
// beats/descriptors/seg_err pulses, compares against hand-computed values.
module tb_ingress_segmenter;

    logic         clk;
    logic         rstn;
    logic [127:0] pkt_data;
    logic         pkt_valid;
    logic         pkt_ready;
    logic         pkt_sop;
    logic         pkt_eop;
    logic [10:0]  pkt_len;
    logic [3:0]   pkt_dport;
    logic [1:0]   pkt_prio;
    logic [127:0] data_in;
    logic         data_wr;
    logic [15:0]  i_cell_ptr_fifo_din;
    logic         i_cell_ptr_fifo_wr;
    logic         i_cell_bp;
    logic         seg_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int seg_cnt = 0;

    logic [127:0] out_q[$];
    int           out_cyc[$];
    logic [15:0]  desc_q[$];
    int           desc_cyc[$];

    ingress_segmenter #(.BEAT_DEPTH(16), .DESC_DEPTH(4)) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .pkt_data            (pkt_data),
        .pkt_valid           (pkt_valid),
        .pkt_ready           (pkt_ready),
        .pkt_sop             (pkt_sop),
        .pkt_eop             (pkt_eop),
        .pkt_len             (pkt_len),
        .pkt_dport           (pkt_dport),
        .pkt_prio            (pkt_prio),
        .data_in             (data_in),
        .data_wr             (data_wr),
        .i_cell_ptr_fifo_din (i_cell_ptr_fifo_din),
        .i_cell_ptr_fifo_wr  (i_cell_ptr_fifo_wr),
        .i_cell_bp           (i_cell_bp),
        .seg_err             (seg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (data_wr) begin
            out_q.push_back(data_in);
            out_cyc.push_back(cyc);
        end
        if (i_cell_ptr_fifo_wr) begin
            desc_q.push_back(i_cell_ptr_fifo_din);
            desc_cyc.push_back(cyc);
        end
        if (seg_err) seg_cnt++;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] beat_data(input logic [7:0] fid, input logic [7:0] k);
        logic [127:0] d;
        for (int i = 0; i < 8; i++) d[i*16 +: 16] = {fid, k};
        return d;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        out_q.delete();
        out_cyc.delete();
        desc_q.delete();
        desc_cyc.delete();
        seg_cnt = 0;
    endtask

    task automatic put_beat(input logic [127:0] d, input logic sop, input logic eop,
                            input logic [10:0] len, input logic [3:0] dp, input logic [1:0] pr);
        int c;
        c = 0;
        pkt_data  = d;
        pkt_sop   = sop;
        pkt_eop   = eop;
        pkt_len   = len;
        pkt_dport = dp;
        pkt_prio  = pr;
        pkt_valid = 1'b1;
        while (!pkt_ready && c < 300) begin
            @(negedge clk);
            c++;
        end
        if (c >= 300) check("ready_timeout", pkt_ready, 1);
        @(negedge clk);
        pkt_valid = 1'b0;
        pkt_sop   = 1'b0;
        pkt_eop   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] fid, input logic [10:0] len,
                              input logic [3:0] dp, input logic [1:0] pr, input int nbeats);
        for (int k = 0; k < nbeats; k++)
            put_beat(beat_data(fid, k[7:0]), k == 0, k == nbeats - 1, len, dp, pr);
    endtask

    task automatic wait_outs(input int n, input int maxc);
        int c;
        c = 0;
        while (out_q.size() < n && c < maxc) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic check_frame(input string tag, input logic [7:0] fid, input int ndata,
                               input int ntotal, input logic contig);
        logic [127:0] obs;
        logic [127:0] exp;
        check({tag, "_cnt"}, out_q.size(), ntotal);
        for (int k = 0; k < ntotal; k++) begin
            obs = (k < out_q.size()) ? out_q[k] : 'x;
            exp = (k < ndata) ? beat_data(fid, k[7:0]) : '0;
            check($sformatf("%s_b%0d", tag, k), obs, exp);
        end
        if (contig && out_q.size() >= ntotal && ntotal > 0)
            check({tag, "_gap"}, out_cyc[ntotal-1] - out_cyc[0], ntotal - 1);
    endtask

    task automatic check_desc(input string tag, input logic [15:0] exp);
        check({tag, "_dcnt"}, desc_q.size(), 1);
        check({tag, "_desc"}, (desc_q.size() > 0) ? desc_q[0] : 16'hxxxx, exp);
        if (desc_q.size() > 0 && out_q.size() > 0)
            check({tag, "_dalign"}, desc_cyc[0], out_cyc[0]);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_data_in"}, data_in, 0);
        check({tag, "_data_wr"}, data_wr, 0);
        check({tag, "_din"}, i_cell_ptr_fifo_din, 0);
        check({tag, "_dwr"}, i_cell_ptr_fifo_wr, 0);
        check({tag, "_seg_err"}, seg_err, 0);
        check({tag, "_ready"}, pkt_ready, 0);
    endtask

    initial begin
        rstn      = 1'b1;
        pkt_data  = '0;
        pkt_valid = 1'b0;
        pkt_sop   = 1'b0;
        pkt_eop   = 1'b0;
        pkt_len   = '0;
        pkt_dport = '0;
        pkt_prio  = '0;
        i_cell_bp = 1'b0;

        // Reset state
        idle(3);
        check_quiet("rst");
        rstn = 1'b0;
        @(negedge clk);
        check("rst_ready_after", pkt_ready, 1);
        clear_logs();

        // 256-byte frame: 4 cells, contiguous 16 beats
        send_frame(8'd1, 11'd256, 4'b0010, 2'd0, 16);
        wait_outs(16, 200);
        idle(10);
        check_frame("t1", 8'd1, 16, 16, 1'b1);
        check_desc("t1", 16'h0204);
        check("t1_segerr", seg_cnt, 0);
        clear_logs();

        // Orphan beat dropped, then 100-byte frame: 2 cells, last beat padded
        put_beat(beat_data(8'd99, 8'd0), 1'b0, 1'b0, 11'd0, 4'b0, 2'd0);
        send_frame(8'd2, 11'd100, 4'b0100, 2'd3, 7);
        wait_outs(8, 200);
        idle(10);
        check_frame("t2", 8'd2, 7, 8, 1'b1);
        check_desc("t2", 16'h04C2);
        check("t2_segerr", seg_cnt, 0);
        clear_logs();

        // 64-byte frame sent as 6 beats: truncation and drain
        send_frame(8'd3, 11'd64, 4'b1000, 2'd1, 6);
        wait_outs(4, 200);
        idle(15);
        check_frame("t3", 8'd3, 4, 4, 1'b1);
        check_desc("t3", 16'h0841);
        check("t3_segerr", seg_cnt, 1);
        clear_logs();

        // Zero-length frame still yields one cell
        send_frame(8'd4, 11'd0, 4'b0001, 2'd0, 1);
        wait_outs(4, 200);
        idle(10);
        check_frame("t3b", 8'd4, 1, 4, 1'b1);
        check_desc("t3b", 16'h0101);
        clear_logs();

        // Backpressure before start and during beat 1
        i_cell_bp = 1'b1;
        send_frame(8'd5, 11'd128, 4'b0010, 2'd1, 8);
        idle(20);
        check("t4_held_out", out_q.size(), 0);
        check("t4_held_desc", desc_q.size(), 0);
        i_cell_bp = 1'b0;
        wait_outs(1, 50);
        @(negedge clk);
        i_cell_bp = 1'b1;
        idle(20);
        check("t4_one_cell", out_q.size(), 4);
        i_cell_bp = 1'b0;
        wait_outs(8, 100);
        idle(10);
        check_frame("t4", 8'd5, 8, 8, 1'b0);
        check_desc("t4", 16'h0242);
        clear_logs();

        // Fill beat FIFO while stalled, then push while draining
        i_cell_bp = 1'b1;
        send_frame(8'd6, 11'd256, 4'b1000, 2'd2, 16);
        check("t5_ready_full", pkt_ready, 0);
        i_cell_bp = 1'b0;
        send_frame(8'd7, 11'd16, 4'b0001, 2'd0, 1);
        wait_outs(20, 200);
        idle(10);
        check("t5_cnt", out_q.size(), 20);
        for (int k = 0; k < 20; k++)
            check($sformatf("t5_b%0d", k), (k < out_q.size()) ? out_q[k] : 'x,
                  (k < 16) ? beat_data(8'd6, k[7:0]) : ((k == 16) ? beat_data(8'd7, 8'd0) : '0));
        check("t5_dcnt", desc_q.size(), 2);
        check("t5_desc0", (desc_q.size() > 0) ? desc_q[0] : 16'hxxxx, 16'h0884);
        check("t5_desc1", (desc_q.size() > 1) ? desc_q[1] : 16'hxxxx, 16'h0101);
        clear_logs();

        // Reset during beat 2 abandons the cell
        i_cell_bp = 1'b1;
        send_frame(8'd8, 11'd128, 4'b0010, 2'd0, 8);
        i_cell_bp = 1'b0;
        wait_outs(3, 50);
        rstn = 1'b1;
        @(negedge clk);
        check_quiet("t6");
        rstn = 1'b0;
        idle(10);
        check("t6_abandon", out_q.size(), 3);
        clear_logs();
        send_frame(8'd9, 11'd32, 4'b0001, 2'd2, 2);
        wait_outs(4, 100);
        idle(10);
        check_frame("t6b", 8'd9, 2, 4, 1'b1);
        check_desc("t6b", 16'h0181);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
